// File: rtl/uparc_lsu.sv
// uparc_lsu: load/store unit. It accepts single-cycle access commands from the
// memory stage and checks their alignment. Each aligned access becomes one
// request/acknowledge transfer on the system data bus. Bytes are laid out
// big-endian on the bus. Load data comes back right-justified and zero-padded,
// and the stage sign- or zero-extends it. Alignment and bus faults are
// reported back to the stage.
module uparc_lsu #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int BUS_TIMEOUT = 255,
    parameter int TMO_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] lsu_addr,
    input  logic [DATA_WIDTH-1:0] lsu_wdata,
    output logic [DATA_WIDTH-1:0] lsu_rdata,
    input  logic [1:0]            lsu_cmd,
    input  logic                  lsu_rnw,
    output logic                  lsu_busy,
    output logic                  lsu_err_align,
    output logic                  lsu_err_bus,
    output logic                  o_bus_rq,
    output logic [ADDR_WIDTH-1:0] o_bus_addr,
    output logic                  o_bus_wnr,
    output logic [3:0]            o_bus_be,
    output logic [DATA_WIDTH-1:0] o_bus_wdata,
    input  logic                  i_bus_ack,
    input  logic                  i_bus_err,
    input  logic [DATA_WIDTH-1:0] i_bus_rdata
);

    typedef enum logic [1:0] {
        CMD_IDLE  = 2'd0,
        CMD_BYTE  = 2'd1,
        CMD_HWORD = 2'd2,
        CMD_WORD  = 2'd3
    } cmd_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // The timeout fires in the BUS_TIMEOUT-th WAIT cycle that has no response.
    localparam bit                   TMO_EN   = (BUS_TIMEOUT != 0);
    localparam logic [TMO_WIDTH-1:0] TMO_LAST =
        TMO_WIDTH'((BUS_TIMEOUT > 0) ? BUS_TIMEOUT - 1 : 0);

    state_t                 state_q, state_d;
    cmd_t                   size_q;
    logic [1:0]             ofs_q;
    logic [TMO_WIDTH-1:0]   tmo_cnt_q;

    logic                   cmd_valid;
    logic                   misaligned;
    logic                   req_accept;
    logic                   tmo_expired;
    logic                   bus_done;
    logic                   bus_fail;
    logic [3:0]             be_d;
    logic [DATA_WIDTH-1:0]  wdata_d;
    logic [4:0]             rd_shift;
    logic [DATA_WIDTH-1:0]  rd_shifted;
    logic [DATA_WIDTH-1:0]  rdata_ext;

    assign cmd_valid  = (lsu_cmd != CMD_IDLE);
    assign misaligned = ((lsu_cmd == CMD_HWORD) && lsu_addr[0]) ||
                        ((lsu_cmd == CMD_WORD)  && (lsu_addr[1:0] != 2'b00));
    // Requests are only accepted in IDLE; a command seen during WAIT is ignored.
    assign req_accept = (state_q == ST_IDLE) && cmd_valid && !misaligned;

    assign tmo_expired = TMO_EN && (tmo_cnt_q == TMO_LAST);
    // Error beats ack, and ack beats a timeout expiring in the same cycle.
    assign bus_fail    = (state_q == ST_WAIT) && (i_bus_err || (tmo_expired && !i_bus_ack));
    assign bus_done    = (state_q == ST_WAIT) && i_bus_ack && !i_bus_err;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples the pre-edge values regardless of block ordering.
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        // NOTE: every always_comb output gets a default first so that no path
        // leaves it unassigned, which would infer a latch.
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (cmd_valid && !misaligned) state_d = ST_WAIT;
            ST_WAIT: if (bus_done || bus_fail)     state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs; busy and the alignment fault respond in the same cycle as the command
    always_comb begin
        lsu_busy      = 1'b0;
        lsu_err_align = 1'b0;
        o_bus_rq      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                lsu_busy      = cmd_valid && !misaligned;
                lsu_err_align = cmd_valid && misaligned;
            end
            ST_WAIT: begin
                lsu_busy = 1'b1;
                o_bus_rq = 1'b1;
            end
            default: ;
        endcase
    end

    // Byte enables and lane-replicated store data for the incoming command
    always_comb begin
        be_d    = 4'b1111;
        wdata_d = lsu_wdata;
        case (cmd_t'(lsu_cmd))
            CMD_BYTE: begin
                be_d    = 4'b1000 >> lsu_addr[1:0];
                wdata_d = {4{lsu_wdata[7:0]}};
            end
            CMD_HWORD: begin
                be_d    = 4'b1100 >> lsu_addr[1:0];
                wdata_d = {2{lsu_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Shift amount that brings the addressed big-endian lane down to bit 0
    always_comb begin
        rd_shift = 5'd0;
        case (size_q)
            CMD_BYTE:  rd_shift = {~ofs_q, 3'b000};
            CMD_HWORD: rd_shift = {~ofs_q[1], 4'b0000};
            default:   rd_shift = 5'd0;
        endcase
    end

    assign rd_shifted = i_bus_rdata >> rd_shift;

    // Right-justify load data and clear the bits above the access size
    always_comb begin
        rdata_ext = i_bus_rdata;
        case (size_q)
            CMD_BYTE:  rdata_ext = {24'd0, rd_shifted[7:0]};
            CMD_HWORD: rdata_ext = {16'd0, rd_shifted[15:0]};
            default:   rdata_ext = i_bus_rdata;
        endcase
    end

    // Capture the bus-side request when an aligned command is accepted
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the request registers are reset as well, because every output
        // must read 0 during reset and not whatever the last transfer left.
        if (rst) begin
            o_bus_addr  <= '0;
            o_bus_wnr   <= 1'b0;
            o_bus_be    <= 4'b0000;
            o_bus_wdata <= '0;
            size_q      <= CMD_IDLE;
            ofs_q       <= 2'b00;
        end else if (req_accept) begin
            o_bus_addr  <= {lsu_addr[ADDR_WIDTH-1:2], 2'b00};
            o_bus_wnr   <= !lsu_rnw;
            o_bus_be    <= be_d;
            o_bus_wdata <= wdata_d;
            size_q      <= cmd_t'(lsu_cmd);
            ofs_q       <= lsu_addr[1:0];
        end
    end

    // Count WAIT cycles; restart from 0 for every transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tmo_cnt_q <= '0;
        else if ((state_q == ST_WAIT) && (state_d == ST_WAIT))
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        else
            tmo_cnt_q <= '0;
    end

    // Completion: bus error pulse and load data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lsu_err_bus <= 1'b0;
            lsu_rdata   <= '0;
        end else begin
            lsu_err_bus <= bus_fail;
            if (bus_fail && !o_bus_wnr)
                lsu_rdata <= '0;
            else if (bus_done && !o_bus_wnr)
                lsu_rdata <= rdata_ext;
        end
    end

endmodule

// File: tb/tb_uparc_lsu.sv
// tb_uparc_lsu: randomized and directed bench for uparc_lsu. A byte-lane model
// of the big-endian bus predicts each result. The DUT is built with a short bus
// timeout so the timeout paths can be reached quickly.
module tb_uparc_lsu;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] lsu_addr = '0;
    logic [31:0] lsu_wdata = '0;
    logic [31:0] lsu_rdata;
    logic [1:0]  lsu_cmd = 2'd0;
    logic        lsu_rnw = 1'b0;
    logic        lsu_busy, lsu_err_align, lsu_err_bus;
    logic        o_bus_rq, o_bus_wnr;
    logic [31:0] o_bus_addr, o_bus_wdata;
    logic [3:0]  o_bus_be;
    logic        i_bus_ack = 1'b0;
    logic        i_bus_err = 1'b0;
    logic [31:0] i_bus_rdata = '0;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_rdata = '0;

    uparc_lsu #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .BUS_TIMEOUT(TMO),
        .TMO_WIDTH  (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .lsu_addr     (lsu_addr),
        .lsu_wdata    (lsu_wdata),
        .lsu_rdata    (lsu_rdata),
        .lsu_cmd      (lsu_cmd),
        .lsu_rnw      (lsu_rnw),
        .lsu_busy     (lsu_busy),
        .lsu_err_align(lsu_err_align),
        .lsu_err_bus  (lsu_err_bus),
        .o_bus_rq     (o_bus_rq),
        .o_bus_addr   (o_bus_addr),
        .o_bus_wnr    (o_bus_wnr),
        .o_bus_be     (o_bus_be),
        .o_bus_wdata  (o_bus_wdata),
        .i_bus_ack    (i_bus_ack),
        .i_bus_err    (i_bus_err),
        .i_bus_rdata  (i_bus_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- reference model: bus lanes as bytes, lane 0 = MSB ----------------
    function automatic int nbytes(input logic [1:0] cmd);
        return (cmd == 2'd1) ? 1 : (cmd == 2'd2) ? 2 : 4;
    endfunction

    function automatic bit model_misaligned(input logic [1:0] cmd, input logic [31:0] addr);
        return (cmd == 2'd2 && addr[0]) || (cmd == 2'd3 && addr[1:0] != 2'b00);
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] cmd, input logic [31:0] addr);
        logic [3:0] be;
        int a;
        be = '0;
        a = int'(addr[1:0]);
        for (int i = 0; i < nbytes(cmd); i++) be[3 - (a + i)] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] cmd, input logic [31:0] wdata);
        logic [31:0] r;
        int n;
        n = nbytes(cmd);
        r = '0;
        for (int lane = 0; lane < 4; lane++)
            r[8*(3-lane) +: 8] = wdata[8*(n-1-(lane % n)) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_rdata(input logic [1:0] cmd, input logic [31:0] addr,
                                                input logic [31:0] bus);
        logic [31:0] r;
        int a;
        a = int'(addr[1:0]);
        r = '0;
        for (int i = 0; i < nbytes(cmd); i++) r = (r << 8) | {24'd0, bus[8*(3-(a+i)) +: 8]};
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One aligned access: issue, hold the bus for 'waits' empty WAIT cycles, then respond.
    task automatic run_xfer(input logic [1:0] cmd, input logic rnw, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] bus_data,
                            input int waits, input bit do_err, input bit do_ack, input string tag);
        int          busy_cycles;
        logic [3:0]  m_be;
        logic [31:0] m_wd;
        busy_cycles = 0;
        m_be = model_be(cmd, addr);
        m_wd = model_wdata(cmd, wdata);
        lsu_cmd = cmd; lsu_rnw = rnw; lsu_addr = addr; lsu_wdata = wdata;
        #1;
        n_checks++;
        if (lsu_busy !== 1'b1 || lsu_err_align !== 1'b0 || o_bus_rq !== 1'b0) begin
            n_fail++;
            $display("FAIL %s issue: busy=%b align=%b rq=%b, required 1/0/0", tag, lsu_busy, lsu_err_align, o_bus_rq);
        end
        if (lsu_busy === 1'b1) busy_cycles++;
        step();
        // Scramble the request inputs while idle; the latched transfer must not move.
        lsu_cmd = 2'd0; lsu_rnw = 1'($urandom); lsu_addr = $urandom; lsu_wdata = $urandom;
        n_checks++;
        if (o_bus_rq !== 1'b1 || o_bus_wnr !== ~rnw || o_bus_be !== m_be || o_bus_addr !== {addr[31:2], 2'b00}) begin
            n_fail++;
            $display("FAIL %s bus: rq=%b wnr=%b be=%b addr=%h, required 1/%b/%b/%h", tag, o_bus_rq, o_bus_wnr,
                     o_bus_be, o_bus_addr, ~rnw, m_be, {addr[31:2], 2'b00});
        end
        if (!rnw) begin
            n_checks++;
            if (o_bus_wdata !== m_wd) begin
                n_fail++;
                $display("FAIL %s wdata: got %h, required %h", tag, o_bus_wdata, m_wd);
            end
        end
        for (int i = 0; i <= waits; i++) begin
            if (i == waits) begin
                i_bus_ack = do_ack; i_bus_err = do_err; i_bus_rdata = bus_data;
            end else begin
                i_bus_rdata = $urandom;
            end
            #1;
            n_checks++;
            if (lsu_busy !== 1'b1 || o_bus_rq !== 1'b1 || o_bus_be !== m_be) begin
                n_fail++;
                $display("FAIL %s wait%0d: busy=%b rq=%b be=%b, required 1/1/%b", tag, i, lsu_busy, o_bus_rq, o_bus_be, m_be);
            end
            if (lsu_busy === 1'b1) busy_cycles++;
            step();
        end
        i_bus_ack = 1'b0; i_bus_err = 1'b0;
        if (rnw) exp_rdata = do_err ? 32'd0 : model_rdata(cmd, addr, bus_data);
        n_checks++;
        if (lsu_busy !== 1'b0 || o_bus_rq !== 1'b0 || lsu_err_bus !== do_err || lsu_rdata !== exp_rdata) begin
            n_fail++;
            $display("FAIL %s done: busy=%b rq=%b err_bus=%b rdata=%h, required 0/0/%b/%h", tag, lsu_busy, o_bus_rq,
                     lsu_err_bus, lsu_rdata, do_err, exp_rdata);
        end
        n_checks++;
        if (busy_cycles !== waits + 2) begin
            n_fail++;
            $display("FAIL %s busy_len: got %0d cycles, required %0d", tag, busy_cycles, waits + 2);
        end
        step();
        n_checks++;
        if (lsu_err_bus !== 1'b0 || lsu_rdata !== exp_rdata || o_bus_rq !== 1'b0) begin
            n_fail++;
            $display("FAIL %s after: err_bus=%b rdata=%h rq=%b, required 0/%h/0", tag, lsu_err_bus, lsu_rdata, o_bus_rq, exp_rdata);
        end
    endtask

    task automatic run_misaligned(input logic [1:0] cmd, input logic rnw, input logic [31:0] addr, input string tag);
        lsu_cmd = cmd; lsu_rnw = rnw; lsu_addr = addr; lsu_wdata = $urandom;
        #1;
        n_checks++;
        if (lsu_err_align !== 1'b1 || lsu_busy !== 1'b0 || o_bus_rq !== 1'b0) begin
            n_fail++;
            $display("FAIL %s align: err_align=%b busy=%b rq=%b, required 1/0/0", tag, lsu_err_align, lsu_busy, o_bus_rq);
        end
        step();
        lsu_cmd = 2'd0;
        #1;
        n_checks++;
        if (lsu_err_align !== 1'b0 || lsu_busy !== 1'b0 || o_bus_rq !== 1'b0 || lsu_rdata !== exp_rdata) begin
            n_fail++;
            $display("FAIL %s align_after: err_align=%b busy=%b rq=%b rdata=%h, required 0/0/0/%h", tag, lsu_err_align,
                     lsu_busy, o_bus_rq, lsu_rdata, exp_rdata);
        end
        step();
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({lsu_rdata, lsu_busy, lsu_err_align, lsu_err_bus, o_bus_rq, o_bus_addr, o_bus_wnr, o_bus_be, o_bus_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_hold: rdata=%h busy=%b rq=%b addr=%h be=%b, required all 0", lsu_rdata, lsu_busy,
                     o_bus_rq, o_bus_addr, o_bus_be);
        end
        rst = 1'b0;
        step();
        n_checks++;
        if ({lsu_rdata, lsu_busy, lsu_err_bus, o_bus_rq} !== '0) begin
            n_fail++;
            $display("FAIL reset_release: rdata=%h busy=%b err_bus=%b rq=%b, required all 0", lsu_rdata, lsu_busy, lsu_err_bus, o_bus_rq);
        end
    endtask

    task automatic test_directed();
        run_xfer(2'd1, 1'b1, 32'h0000_1001, 32'h0, 32'h1122_3344, 0, 1'b0, 1'b1, "lb_1001");
        n_checks++;
        if (lsu_rdata !== 32'h0000_0022 || o_bus_be !== 4'b0100 || o_bus_addr !== 32'h0000_1000) begin
            n_fail++;
            $display("FAIL lb_1001_const: rdata=%h be=%b addr=%h, required 00000022/0100/00001000", lsu_rdata, o_bus_be, o_bus_addr);
        end
        // Ack arrives in the very cycle the timeout would expire: ack must win.
        run_xfer(2'd2, 1'b0, 32'h0000_2002, 32'hABCD_1234, 32'hFFFF_FFFF, TMO - 1, 1'b0, 1'b1, "sh_2002");
        n_checks++;
        if (o_bus_wdata !== 32'h1234_1234 || o_bus_be !== 4'b0011 || o_bus_wnr !== 1'b1 || lsu_rdata !== 32'h0000_0022) begin
            n_fail++;
            $display("FAIL sh_2002_const: wdata=%h be=%b wnr=%b rdata=%h, required 12341234/0011/1/00000022", o_bus_wdata,
                     o_bus_be, o_bus_wnr, lsu_rdata);
        end
    endtask

    task automatic test_align();
        run_misaligned(2'd3, 1'b1, 32'h0000_3002, "lw_3002");
        run_misaligned(2'd2, 1'b1, 32'h0000_3003, "lh_3003");
    endtask

    task automatic test_bus_err();
        run_xfer(2'd3, 1'b1, 32'h0000_4000, 32'h0, 32'hDEAD_BEEF, 2, 1'b1, 1'b0, "lw_err");
        run_xfer(2'd3, 1'b1, 32'h0000_4000, 32'h0, 32'h5566_7788, 1, 1'b0, 1'b1, "lw_after_err");
        run_xfer(2'd3, 1'b1, 32'h0000_4004, 32'h0, 32'h0102_0304, 0, 1'b1, 1'b1, "ack_err_same");
    endtask

    task automatic test_timeout();
        int rq_cycles;
        rq_cycles = 0;
        lsu_cmd = 2'd3; lsu_rnw = 1'b1; lsu_addr = 32'h0000_5000;
        step();
        lsu_cmd = 2'd0;
        while (o_bus_rq === 1'b1 && rq_cycles < 20) begin
            rq_cycles++;
            step();
        end
        exp_rdata = 32'd0;
        n_checks++;
        if (rq_cycles !== TMO) begin
            n_fail++;
            $display("FAIL timeout_len: rq high %0d cycles, required %0d", rq_cycles, TMO);
        end
        n_checks++;
        if (lsu_err_bus !== 1'b1 || lsu_busy !== 1'b0 || lsu_rdata !== exp_rdata) begin
            n_fail++;
            $display("FAIL timeout_err: err_bus=%b busy=%b rdata=%h, required 1/0/%h", lsu_err_bus, lsu_busy, lsu_rdata, exp_rdata);
        end
        step();
        n_checks++;
        if (lsu_err_bus !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_pulse: err_bus=%b one cycle later, required 0", lsu_err_bus);
        end
    endtask

    task automatic test_wait_ignore();
        logic [31:0] bus;
        bus = 32'hCAFE_BABE;
        lsu_cmd = 2'd2; lsu_rnw = 1'b1; lsu_addr = 32'h0000_6002;
        step();
        lsu_cmd = 2'd3; lsu_rnw = 1'b0; lsu_addr = 32'h0000_6001;
        #1;
        n_checks++;
        if (lsu_err_align !== 1'b0 || lsu_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL ignore_misaligned: err_align=%b busy=%b, required 0/1", lsu_err_align, lsu_busy);
        end
        step();
        lsu_cmd = 2'd1; lsu_rnw = 1'b0; lsu_addr = 32'h0000_7000;
        i_bus_ack = 1'b1; i_bus_rdata = bus;
        #1;
        n_checks++;
        if (o_bus_addr !== 32'h0000_6000 || o_bus_be !== 4'b0011 || o_bus_wnr !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_stable: addr=%h be=%b wnr=%b, required 00006000/0011/0", o_bus_addr, o_bus_be, o_bus_wnr);
        end
        step();
        lsu_cmd = 2'd0; i_bus_ack = 1'b0;
        exp_rdata = model_rdata(2'd2, 32'h0000_6002, bus);
        step();
        n_checks++;
        if (lsu_rdata !== exp_rdata || lsu_busy !== 1'b0 || o_bus_rq !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_result: rdata=%h busy=%b rq=%b, required %h/0/0", lsu_rdata, lsu_busy, o_bus_rq, exp_rdata);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 60; k++) begin
            logic [1:0]  cmd;
            logic [31:0] addr;
            bit          fail;
            cmd  = 2'($urandom_range(1, 3));
            addr = $urandom;
            fail = ($urandom_range(0, 5) == 0);
            if (model_misaligned(cmd, addr))
                run_misaligned(cmd, 1'($urandom), addr, $sformatf("rnd%0d", k));
            else
                run_xfer(cmd, 1'($urandom), addr, $urandom, $urandom, $urandom_range(0, TMO - 1),
                         fail, fail ? 1'($urandom) : 1'b1, $sformatf("rnd%0d", k));
        end
    endtask

    task automatic test_reset_mid();
        run_xfer(2'd3, 1'b1, 32'h0000_8004, 32'h0, 32'h1234_5678, 0, 1'b0, 1'b1, "lw_pre_reset");
        lsu_cmd = 2'd3; lsu_rnw = 1'b1; lsu_addr = 32'h0000_8000;
        step();
        lsu_cmd = 2'd0;
        step();
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (o_bus_rq !== 1'b0 || lsu_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: rq=%b busy=%b before next edge, required 0/0", o_bus_rq, lsu_busy);
        end
        step();
        step();
        rst = 1'b0;
        exp_rdata = 32'd0;
        #1;
        n_checks++;
        if ({lsu_rdata, lsu_err_bus, o_bus_rq, o_bus_addr, o_bus_be, o_bus_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_clear: rdata=%h rq=%b addr=%h be=%b, required all 0", lsu_rdata, o_bus_rq, o_bus_addr, o_bus_be);
        end
        run_xfer(2'd1, 1'b1, 32'h0000_0003, 32'h0, 32'h0000_00F0, 0, 1'b0, 1'b1, "lb_0003");
        n_checks++;
        if (lsu_rdata !== 32'h0000_00F0) begin
            n_fail++;
            $display("FAIL lb_0003_const: rdata=%h, required 000000F0", lsu_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_align();
        test_bus_err();
        test_timeout();
        test_wait_ignore();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
